// File: rtl/div_clock_prog.sv
// Programmable clock divider: counts 0..div_active, then emits a one-cycle tick and toggles clk_div.
// New terminal values are held in a shadow register until the next wrap so the current period is never cut short.
module div_clock_prog #(
   parameter int              WIDTH      = 15,
   parameter logic [WIDTH-1:0] RESET_TERM = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic             div_load,
   input  logic [WIDTH-1:0] div_value,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             clk_div,
   output logic [WIDTH-1:0] div_active,
   output logic             div_pending
);

   logic [WIDTH-1:0] r_count;
   logic             r_tick;
   logic             r_clk_div;
   logic [WIDTH-1:0] r_div_active;
   logic [WIDTH-1:0] r_div_shadow;
   logic             r_div_pending;

   logic             w_wrap;
   logic             w_wrap_edge;

   // >= lets a count stranded above a freshly shrunk terminal still wrap
   assign w_wrap      = en && (r_count >= r_div_active);
   assign w_wrap_edge = !clr && w_wrap;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count   <= '0;
         r_tick    <= 1'b0;
         r_clk_div <= 1'b0;
      end else if (clr) begin
         r_count   <= '0;
         r_tick    <= 1'b0;
         r_clk_div <= 1'b0;
      end else if (w_wrap) begin
         r_count   <= '0;
         r_tick    <= 1'b1;
         r_clk_div <= ~r_clk_div;
      end else if (en) begin
         r_count   <= r_count + 1'b1;
         r_tick    <= 1'b0;
      end else begin
         r_tick    <= 1'b0;
      end
   end

   // A load mid-period is parked in the shadow; on a wrap edge or while idle it takes effect at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div_active  <= RESET_TERM;
         r_div_shadow  <= '0;
         r_div_pending <= 1'b0;
      end else if (div_load) begin
         if (en && !w_wrap_edge) begin
            r_div_shadow  <= div_value;
            r_div_pending <= 1'b1;
         end else begin
            r_div_active  <= div_value;
            r_div_pending <= 1'b0;
         end
      end else if (w_wrap_edge && r_div_pending) begin
         r_div_active  <= r_div_shadow;
         r_div_pending <= 1'b0;
      end
   end

   assign count       = r_count;
   assign tick        = r_tick;
   assign clk_div     = r_clk_div;
   assign div_active  = r_div_active;
   assign div_pending = r_div_pending;

endmodule
